round_mult_pipe: RTL and testbench
==================================

Name: round_mult_pipe

Overview:
Pipelined, parametrised rounding stage for the FP multiplier datapath. It sits between the normaliser and the result packer. It takes a normalised mantissa, exponent, guard, sticky and sign per transaction, and applies a rounding mode chosen per transaction at run time rather than fixed at elaboration. The rounded mantissa and exponent are returned over a valid/ready handshake with back-pressure.

Parameters:
MANT_W, 24, mantissa width including hidden bit (24 = single precision, 53 = double)
EXP_W, 10, biased exponent width (includes overflow/underflow headroom bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
in_mant  input  MANT_W  normalised mantissa, MSB = hidden bit
in_exp  input  EXP_W  normalised exponent
in_guard  input  1  guard bit
in_sticky  input  1  sticky bit
in_sign  input  1  result sign (1 = negative)
in_mode  input  3  rounding mode: 0 IEEE_near, 1 IEEE_zero, 2 IEEE_pinf, 3 IEEE_ninf, 4 near_up, 5 away_zero; 6 and 7 behave as 0
out_valid  output  1  output transaction valid
out_ready  input  1  downstream accepts output
out_mant  output  MANT_W  rounded, renormalised mantissa
out_exp  output  EXP_W  rounded exponent
out_sign  output  1  sign passed through
out_inexact  output  1  guard | sticky
out_carry  output  1  rounding carried out and mantissa was renormalised
out_exp_wrap  output  1  carry incremented out_exp from all-ones to zero

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high on rst.
- Reset values: in the cycle after rst is sampled high, out_valid, out_mant, out_exp, out_sign, out_inexact, out_carry and out_exp_wrap are all 0.
- Reset mid-operation: all in-flight transactions are discarded and never presented.
- Pipeline structure:
  - Stage 1 registers the operands plus a one-bit increment decision (inc).
  - Stage 2 registers {1'b0, mant} + inc and renormalises.
  - Latency is 2 cycles from the in_valid&in_ready edge to out_valid with no stall. Throughput is 1 per cycle.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational, with no dependency on in_valid.
  - Transfer occurs only on valid&ready.
  - Outputs hold stable while out_valid & !out_ready.
  - Empty stages accept bubbles.
  - No transaction is dropped or duplicated. Order is preserved.
- Increment decision, with g = in_guard, s = in_sticky, inexact = g|s:
  - If inexact = 0: inc = 0 for every mode.
  - Mode 0 (IEEE_near): inc = g & (s | mant[0]), i.e. ties to even.
  - Mode 1 (IEEE_zero): inc = 0.
  - Mode 2 (IEEE_pinf): inc = !sign.
  - Mode 3 (IEEE_ninf): inc = sign.
  - Mode 4 (near_up): positive: inc = g. Negative: inc = g & s.
  - Mode 5 (away_zero): inc = 1.
- Width and carry rules:
  - Sum is MANT_W+1 bits. If sum[MANT_W] = 1, then out_mant = sum[MANT_W:1] and out_exp = in_exp + 1, with out_carry = 1. Otherwise out_mant = sum[MANT_W-1:0] and out_exp = in_exp.
  - out_exp wraps modulo 2^EXP_W with no saturation. out_exp_wrap = carry & (in_exp == all-ones).
  - Overflow and underflow classification belongs to the packer, not this block.
- Mode sampling: mode is sampled with its own transaction. Changing in_mode between transactions never affects transactions already in flight.

Optional Feature:
Macro ROUND_STATS_EN.
- When defined, add:
  - input stats_clr (1 bit)
  - output stat_inexact (32 bits): count of inexact transactions accepted at stage 2
  - output stat_incr (32 bits): count of stage-2 transactions with inc = 1
- Both counters saturate at 0xFFFFFFFF.
- rst or stats_clr clears both counters to 0. A clear has priority over a same-cycle increment.
- When not defined, these ports and counters are absent and datapath behaviour is identical.

Test Plan:
- Tie to even, MANT_W=24, mode 0, g=1, s=0: mant 0x800001 -> 0x800002, inexact=1. mant 0x800000 -> 0x800000. out_exp unchanged in both.
- Carry, mode 0: mant 0xFFFFFF, exp 0x07F, g=1, s=1 -> mant 0x800000, exp 0x080, carry=1. Same with exp 0x3FF -> exp 0x000, exp_wrap=1.
- Directed modes, mant 0x800000, g=0, s=1, sign=1: mode 1 -> 0x800000; mode 2 -> 0x800000; mode 3 -> 0x800001; mode 4 -> 0x800000; mode 5 -> 0x800001; mode 7 -> 0x800000.
- Exact input, g=0, s=0, mode 5, mant 0xABCDEF -> 0xABCDEF, inexact=0, carry=0.
- Back-pressure: 6 back-to-back inputs, out_ready low for 3 cycles mid-stream -> in_ready falls once both stages are full, outputs held stable, all 6 results emerge in order with no duplicates.
- Reset mid-flight: rst asserted with both stages valid -> out_valid=0 next cycle, flushed results never appear, next input emerges 2 cycles after acceptance. With ROUND_STATS_EN, counters read 0.

Source files
------------

// File: rtl/round_mult_pipe.sv
// rtl/round_mult_pipe.sv - two-stage run-time-mode rounding stage for the FP multiplier (optional stats: ROUND_STATS_EN)

module round_mult_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_guard,
    input  logic              in_sticky,
    input  logic              in_sign,
    input  logic [2:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_inexact,
    output logic              out_carry,
`ifdef ROUND_STATS_EN
    output logic              out_exp_wrap,
    input  logic              stats_clr,
    output logic [31:0]       stat_inexact,
    output logic [31:0]       stat_incr
`else
    output logic              out_exp_wrap
`endif
);

    // Stage 1 holds the operands and the already-resolved increment decision,
    // so the mode never travels past stage 1.
    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign;
    logic              s1_inexact;
    logic              s1_inc;

    logic              s2_valid;
    logic              s2_adv;
    logic              s1_adv;

    logic              inexact_d;
    logic              inc_d;

    logic [MANT_W:0]   sum;
    logic              carry;
    logic [MANT_W-1:0] mant_n;
    logic [EXP_W-1:0]  exp_n;
    logic              wrap_n;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign inexact_d = in_guard | in_sticky;

    // Resolve the increment for the incoming transaction from its own mode.
    always_comb begin
        inc_d = 1'b0;
        if (inexact_d) begin
            case (in_mode)
                3'd1:    inc_d = 1'b0;
                3'd2:    inc_d = !in_sign;
                3'd3:    inc_d = in_sign;
                3'd4:    inc_d = in_sign ? (in_guard & in_sticky) : in_guard;
                3'd5:    inc_d = 1'b1;
                default: inc_d = in_guard & (in_sticky | in_mant[0]);
            endcase
        end
    end

    // Stage 1 register: capture operands whenever a transfer happens, bubble otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_mant    <= '0;
            s1_exp     <= '0;
            s1_sign    <= 1'b0;
            s1_inexact <= 1'b0;
            s1_inc     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant    <= in_mant;
                s1_exp     <= in_exp;
                s1_sign    <= in_sign;
                s1_inexact <= inexact_d;
                s1_inc     <= inc_d;
            end
        end
    end

    // Add the increment and renormalise; a carry-out can only produce 1.000...0.
    always_comb begin
        sum    = {1'b0, s1_mant} + {{MANT_W{1'b0}}, s1_inc};
        carry  = sum[MANT_W];
        mant_n = carry ? sum[MANT_W:1] : sum[MANT_W-1:0];
        exp_n  = s1_exp + {{(EXP_W-1){1'b0}}, carry};
        wrap_n = carry & (&s1_exp);
    end

    // Stage 2 register drives the outputs directly and holds them while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_mant     <= '0;
            out_exp      <= '0;
            out_sign     <= 1'b0;
            out_inexact  <= 1'b0;
            out_carry    <= 1'b0;
            out_exp_wrap <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_mant     <= mant_n;
                out_exp      <= exp_n;
                out_sign     <= s1_sign;
                out_inexact  <= s1_inexact;
                out_carry    <= carry;
                out_exp_wrap <= wrap_n;
            end
        end
    end

`ifdef ROUND_STATS_EN
    // Saturating event counters over transactions entering stage 2; clear wins.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stat_inexact <= '0;
            stat_incr    <= '0;
        end else if (s1_valid && s2_adv) begin
            if (s1_inexact && (stat_inexact != 32'hFFFF_FFFF)) begin
                stat_inexact <= stat_inexact + 32'd1;
            end
            if (s1_inc && (stat_incr != 32'hFFFF_FFFF)) begin
                stat_incr <= stat_incr + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_round_mult_pipe.sv
// tb/tb_round_mult_pipe.sv - scoreboard bench for round_mult_pipe with directed vectors

module tb_round_mult_pipe;

    typedef struct packed {
        logic [23:0] mant;
        logic [9:0]  exp;
        logic        sign;
        logic        inexact;
        logic        carry;
        logic        wrap;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [9:0]  in_exp;
    logic        in_guard;
    logic        in_sticky;
    logic        in_sign;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [9:0]  out_exp;
    logic        out_sign;
    logic        out_inexact;
    logic        out_carry;
    logic        out_exp_wrap;
`ifdef ROUND_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] stat_inexact;
    logic [31:0] stat_incr;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb[$];
    logic saw_in_ready_low = 1'b0;

    always #5 clk = !clk;

    round_mult_pipe #(.MANT_W(24), .EXP_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mant      (in_mant),
        .in_exp       (in_exp),
        .in_guard     (in_guard),
        .in_sticky    (in_sticky),
        .in_sign      (in_sign),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mant     (out_mant),
        .out_exp      (out_exp),
        .out_sign     (out_sign),
        .out_inexact  (out_inexact),
        .out_carry    (out_carry),
`ifdef ROUND_STATS_EN
        .out_exp_wrap (out_exp_wrap),
        .stats_clr    (stats_clr),
        .stat_inexact (stat_inexact),
        .stat_incr    (stat_incr)
`else
        .out_exp_wrap (out_exp_wrap)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic res_t cur_out();
        return '{out_mant, out_exp, out_sign, out_inexact, out_carry, out_exp_wrap};
    endfunction

    // Present one transaction until accepted; expectation is queued at acceptance.
    task automatic send(input logic [23:0] m, input logic [9:0] e, input logic g,
                        input logic s, input logic sg, input logic [2:0] md, input res_t want);
        bit done = 0;
        in_valid  = 1'b1;
        in_mant   = m;
        in_exp    = e;
        in_guard  = g;
        in_sticky = s;
        in_sign   = sg;
        in_mode   = md;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(want);
                done = 1;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never high for mant 0x%0h", m);
        end
    endtask

    // Monitor: pops on every output transfer and verifies stalled outputs stay put.
    initial begin
        res_t held;
        logic stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", {63'd0, out_valid}, 64'd1);
                    check("hold_data", {22'd0, cur_out()}, {22'd0, held});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got mant 0x%0h exp 0x%0h", out_mant, out_exp);
                    end else begin
                        res_t w;
                        w = sb.pop_front();
                        check("out_mant", {40'd0, out_mant}, {40'd0, w.mant});
                        check("out_exp", {54'd0, out_exp}, {54'd0, w.exp});
                        check("out_flags", {60'd0, out_sign, out_inexact, out_carry, out_exp_wrap},
                              {60'd0, w.sign, w.inexact, w.carry, w.wrap});
                    end
                end
                stalled = out_valid && !out_ready;
                held    = cur_out();
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        in_guard  = 1'b0;
        in_sticky = 1'b0;
        in_sign   = 1'b0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_data", {22'd0, cur_out()}, 64'd0);
        rst = 1'b0;

        // Ties to even and carry/wrap cases.
        send(24'h800001, 10'h07F, 1, 0, 0, 3'd0, '{24'h800002, 10'h07F, 0, 1, 0, 0});
        send(24'h800000, 10'h07F, 1, 0, 0, 3'd0, '{24'h800000, 10'h07F, 0, 1, 0, 0});
        send(24'hFFFFFF, 10'h07F, 1, 1, 0, 3'd0, '{24'h800000, 10'h080, 0, 1, 1, 0});
        send(24'hFFFFFF, 10'h3FF, 1, 1, 0, 3'd0, '{24'h800000, 10'h000, 0, 1, 1, 1});
        // Directed modes, negative, sticky only.
        send(24'h800000, 10'h100, 0, 1, 1, 3'd1, '{24'h800000, 10'h100, 1, 1, 0, 0});
        send(24'h800000, 10'h100, 0, 1, 1, 3'd2, '{24'h800000, 10'h100, 1, 1, 0, 0});
        send(24'h800000, 10'h100, 0, 1, 1, 3'd3, '{24'h800001, 10'h100, 1, 1, 0, 0});
        send(24'h800000, 10'h100, 0, 1, 1, 3'd4, '{24'h800000, 10'h100, 1, 1, 0, 0});
        send(24'h800000, 10'h100, 0, 1, 1, 3'd5, '{24'h800001, 10'h100, 1, 1, 0, 0});
        send(24'h800000, 10'h100, 0, 1, 1, 3'd7, '{24'h800000, 10'h100, 1, 1, 0, 0});
        // Exact input never rounds, positive-side directed modes, mode 6 tie.
        send(24'hABCDEF, 10'h055, 0, 0, 0, 3'd5, '{24'hABCDEF, 10'h055, 0, 0, 0, 0});
        send(24'h800000, 10'h001, 1, 0, 0, 3'd4, '{24'h800001, 10'h001, 0, 1, 0, 0});
        send(24'h800000, 10'h001, 0, 1, 0, 3'd2, '{24'h800001, 10'h001, 0, 1, 0, 0});
        send(24'h800003, 10'h001, 1, 0, 1, 3'd6, '{24'h800004, 10'h001, 1, 1, 0, 0});

        // Back-pressure: six back-to-back inputs with a three-cycle stall.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(24'h900000 + 24'(i), 10'(i), 1, 0, 0, 3'd5,
                         '{24'h900001 + 24'(i), 10'(i), 0, 1, 0, 0});
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (!in_ready) saw_in_ready_low = 1'b1;
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_in_ready_fell", {63'd0, saw_in_ready_low}, 64'd1);
        repeat (6) @(posedge clk);
        #1;

        // Reset with both stages full: flushed items must never appear.
        out_ready = 1'b0;
        send(24'hC00000, 10'h010, 1, 1, 0, 3'd5, '{24'hC00001, 10'h010, 0, 1, 0, 0});
        send(24'hC00002, 10'h011, 1, 1, 0, 3'd5, '{24'hC00003, 10'h011, 0, 1, 0, 0});
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_data", {22'd0, cur_out()}, 64'd0);
`ifdef ROUND_STATS_EN
        check("flush_stat_inexact", {32'd0, stat_inexact}, 64'd0);
        check("flush_stat_incr", {32'd0, stat_incr}, 64'd0);
`endif
        send(24'hA00000, 10'h020, 0, 0, 1, 3'd0, '{24'hA00000, 10'h020, 1, 0, 0, 0});
        @(negedge clk);
        check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);

        for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
